// File: rtl/btb_port_sched.sv
// rtl/btb_port_sched.sv - single-port BTB access scheduler with update FIFO and drain sequence
// Optional feature: define BTB_UPD_COALESCE_EN to merge an update into the youngest queued entry with the same PC.
module btb_port_sched #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lk_valid,
  input  logic [31:0]              lk_pc,
  output logic                     lk_ready,
  input  logic                     up_valid,
  input  logic [31:0]              up_pc,
  input  logic [31:0]              up_target,
  input  logic                     up_taken,
  output logic                     up_ready,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     btb_isbranch,
  output logic [31:0]              btb_currentPC,
  output logic                     btb_update,
  output logic [31:0]              btb_branchPC,
  output logic [31:0]              btb_resultPC,
  output logic                     btb_taken
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [31:0]   q_pc     [DEPTH];
  logic [31:0]   q_target [DEPTH];
  logic          q_taken  [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [7:0]    starve_cnt;
  logic [AW:0]   occ_nxt;

  logic          not_empty;
  logic          lk_grant;
  logic          upd_grant;
  logic          enq;
  logic          push;
  logic          coalesce;

  assign not_empty = (occupancy != '0);
  // A full FIFO refuses new updates even if the head pops this cycle.
  assign up_ready  = !rst && (state == RUN) && (occupancy < (AW+1)'(DEPTH));
  assign enq       = up_valid && up_ready;
  assign lk_ready  = lk_grant;

  // Share the single BTB slot: lookups win unless starved updates hit the limit; drain pops only.
  always_comb begin
    lk_grant  = 1'b0;
    upd_grant = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          upd_grant = not_empty && (!lk_valid || (starve_cnt == 8'(STARVE_LIMIT)));
          lk_grant  = lk_valid && !upd_grant;
        end
        DRAIN:   upd_grant = not_empty;
        default: ;
      endcase
    end
  end

`ifdef BTB_UPD_COALESCE_EN
  logic [AW-1:0] youngest;
  assign youngest = tail - AW'(1);
  // Merging is skipped when the youngest entry is also the head leaving this cycle.
  assign coalesce = enq && not_empty && (q_pc[youngest] == up_pc) &&
                    !(upd_grant && (occupancy == (AW+1)'(1)));
`else
  assign coalesce = 1'b0;
`endif

  assign push    = enq && !coalesce;
  assign occ_nxt = occupancy + {{AW{1'b0}}, push} - {{AW{1'b0}}, upd_grant};

  // Update storage: append at tail, or rewrite the youngest entry when merging.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]     <= up_pc;
      q_target[tail] <= up_target;
      q_taken[tail]  <= up_taken;
    end
`ifdef BTB_UPD_COALESCE_EN
    else if (coalesce) begin
      q_target[youngest] <= up_target;
      q_taken[youngest]  <= up_taken;
    end
`endif
  end

  // Pointers, occupancy and the count of lookups that overtook a pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      occupancy  <= '0;
      starve_cnt <= 8'd0;
    end else begin
      if (push)      tail <= tail + AW'(1);
      if (upd_grant) head <= head + AW'(1);
      occupancy <= occ_nxt;
      if (upd_grant || !not_empty) starve_cnt <= 8'd0;
      else if (lk_grant)           starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Drain state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Drain sequencing: leave DRAIN as soon as the last entry is popped, pulse done once.
  always_comb begin
    state_nxt  = state;
    drain_done = 1'b0;
    case (state)
      RUN:   if (drain_req) state_nxt = DRAIN;
      DRAIN: if (occ_nxt == '0) state_nxt = DONE;
      DONE: begin
        drain_done = !rst;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // BTB port registers: strobes last one cycle, data fields hold their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_isbranch  <= 1'b0;
      btb_currentPC <= 32'd0;
      btb_update    <= 1'b0;
      btb_branchPC  <= 32'd0;
      btb_resultPC  <= 32'd0;
      btb_taken     <= 1'b0;
    end else begin
      btb_isbranch <= lk_grant;
      btb_update   <= upd_grant;
      if (lk_grant) btb_currentPC <= lk_pc;
      if (upd_grant) begin
        btb_branchPC <= q_pc[head];
        btb_resultPC <= q_target[head];
        btb_taken    <= q_taken[head];
      end
    end
  end

endmodule

// File: doc/btb_port_sched.md
# btb_port_sched

Scheduler for the single-ported branch target buffer. It buffers resolved-branch updates from the execute stage in a small FIFO and shares the one BTB access slot per cycle between fetch lookups and queued updates. Lookups have priority, with a starvation bound for updates. It also provides a drain sequence so the pipeline can flush all pending updates into the BTB before a redirect.

## Interface

Parameters:
- DEPTH, 4: update FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8: maximum consecutive lookup grants while an update is pending; range 1–255.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- lk_valid  in  1  fetch requests a BTB lookup.
- lk_pc  in  32  lookup PC.
- lk_ready  out  1  lookup granted this cycle (combinational from state/occupancy/lk_valid).
- up_valid  in  1  resolved branch update offered.
- up_pc  in  32  branch PC.
- up_target  in  32  resolved target PC.
- up_taken  in  1  resolved direction.
- up_ready  out  1  update accepted if up_valid; equals (state==RUN && occupancy<DEPTH).
- drain_req  in  1  one-cycle request to flush the FIFO into the BTB.
- drain_done  out  1  one-cycle pulse when the drain completes.
- occupancy  out  $clog2(DEPTH)+1  queued entries (registered).
- btb_isbranch  out  1  registered; BTB lookup strobe.
- btb_currentPC  out  32  registered; lookup PC.
- btb_update  out  1  registered; BTB update strobe.
- btb_branchPC  out  32  registered; update PC.
- btb_resultPC  out  32  registered; update target.
- btb_taken  out  1  registered; update direction.

## Operation

- FIFO:
  - Circular, head/tail pointers, wrap modulo DEPTH.
  - Enqueue on up_valid && up_ready.
  - Pop when an update slot is granted.
  - An entry enqueued in cycle t becomes eligible in t+1; there is no bypass.
  - When full, up_ready=0 even if a pop occurs the same cycle.
- starve_cnt (8 bit):
  - Increments when a lookup is granted while occupancy>0.
  - Clears when an update is granted or occupancy==0.
- Per-cycle arbitration in RUN, mutually exclusive:
  - Update slot: occupancy>0 && (!lk_valid || starve_cnt==STARVE_LIMIT). lk_ready=0.
  - Otherwise lookup slot: lk_ready=lk_valid.
  - Otherwise idle.
- FSM states:
  - RUN: normal arbitration. drain_req moves to DRAIN. A lookup may still be granted in the cycle drain_req is seen.
  - DRAIN: lk_ready=0, up_ready=0. One pop per cycle. When occupancy reaches 0 with no pop pending, move to DONE.
  - DONE: drain_done=1 for one cycle, then RUN.
  - drain_req received in DRAIN or DONE is ignored.
  - drain_req with an empty FIFO gives RUN→DRAIN→DONE, so drain_done rises 2 cycles after the request.
- Reset:
  - State RUN, FIFO empty, starve_cnt=0.
  - All outputs 0; up_ready and lk_ready are 0 during the rst cycle.
  - rst mid-drain discards queued entries with no drain_done pulse.

## Timing

- Grant in cycle t puts the BTB strobe in t+1 for exactly one cycle:
  - Lookup: btb_isbranch=1, btb_currentPC=lk_pc.
  - Update: btb_update=1, btb_branchPC/btb_resultPC/btb_taken from the head entry.
- The non-strobe btb_* fields hold their last value.
- At most one of btb_isbranch and btb_update is high in any cycle.
- Update latency from up_valid acceptance to btb_update is ≥2 cycles. With continuous lookups it is bounded by 2+STARVE_LIMIT+(entries ahead)×(STARVE_LIMIT+1).
- DRAIN with N entries: btb_update on N consecutive cycles, and drain_done one cycle after the last pop.

## Configuration

- BTB_UPD_COALESCE_EN defined:
  - An accepted update whose up_pc equals the youngest queued entry's PC overwrites that entry's target and taken in place. Occupancy is unchanged.
  - Coalescing does not apply if that entry is being popped in the same cycle; the update is appended instead.
  - up_ready rules are unchanged.
- Not defined: every accepted update is appended.

## Test plan

- Reset: hold rst 2 cycles with up_valid=1 → occupancy=0, all btb_* = 0, up_ready=0 during rst, nothing enqueued.
- Lookup only: lk_valid=1, lk_pc=0x1000 at t → btb_isbranch=1, btb_currentPC=0x1000 at t+1 only.
- Starvation, STARVE_LIMIT=8: enqueue 1 update (pc 0x40, target 0x80), then hold lk_valid=1 → 8 lookup grants, then lk_ready=0 for one cycle and btb_update=1, btb_branchPC=0x40, btb_resultPC=0x80; lookups then resume.
- Full: DEPTH=4, 5 back-to-back up_valid with lk_valid=1 → up_ready=0 on the 5th, occupancy=4, the 5th is held by the source.
- Drain: 3 queued entries, pulse drain_req → 3 consecutive btb_update pulses in FIFO order, lk_ready=0 throughout, single drain_done, then RUN.
- Coalesce (macro on): two updates pc 0x40, targets 0x80 then 0xC0, with lk_valid=1 → occupancy=1; the eventual btb_resultPC=0xC0. Macro off → occupancy=2, two updates issued.
